branch_resolver: RTL and testbench
==================================

// Module: branch_resolver
// PURPOSE
//  Execute-side partner of the instruction fetch controller. Fetch stalls after issuing a
//  control-flow instruction; this block waits for the operands, resolves the target and
//  hands it back on npc/get_npc so fetch resumes. Also produces the JAL/JALR link
//  write-back (pc+4 -> rd). Sits between decoder/regfile outputs and fetch.
// PARAMETERS
//  XLEN      32  datapath / PC width
//  PC_STEP   4   sequential PC increment
// PORTS
//  clk           in   1     clock, all state on posedge
//  rst_n         in   1     synchronous reset, active-low
//  opcode        in   7     decoded opcode of instruction leaving fetch
//  fun3          in   3     decoded fun3 (branch condition)
//  rd            in   5     decoded destination register
//  imm           in   XLEN  decoded sign-extended immediate
//  opc           in   XLEN  PC of the decoded instruction
//  rs1_val       in   XLEN  rs1 operand from regfile/forwarding
//  rs2_val       in   XLEN  rs2 operand
//  ops_valid     in   1     rs1_val/rs2_val valid this cycle
//  npc           out  XLEN  resolved next PC, valid while get_npc=1
//  get_npc       out  1     1-cycle pulse: fetch loads npc
//  link_we       out  1     1-cycle pulse, with get_npc, for JAL/JALR only
//  link_rd       out  5     link destination register
//  link_data     out  XLEN  captured opc + PC_STEP
//  taken         out  1     qualifies get_npc: 1 = redirect taken
//  misalign      out  1     qualifies get_npc: target[1:0] != 0
//  illegal       out  1     qualifies get_npc: reserved branch fun3 (010/011)
//  busy          out  1     1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; every output reg = 0; ctrl-flow inputs ignored.
//  FSM IDLE -> WAIT_OPS -> RESOLVE -> IDLE.
//  IDLE: opcode in {OP_BRANCH, OP_JAL, OP_JALR} -> capture opc/imm/fun3/rd/opcode, go WAIT_OPS.
//   Any other opcode (incl. OP_NOP) -> stay.
//  WAIT_OPS: ops_valid=1 -> latch rs1_val/rs2_val, go RESOLVE; else hold. Opcode input ignored
//   (fetch presents only NOPs while stalled). JAL still waits one ops_valid for uniformity.
//  RESOLVE (always 1 cycle): compute, register outputs, go IDLE.
//   BRANCH: BEQ/BNE eq; BLT/BGE signed; BLTU/BGEU unsigned.
//    taken -> npc = opc+imm; else npc = opc+PC_STEP.
//   JAL:  npc = opc+imm; JALR: npc = (rs1+imm) & ~1; both taken=1, link_we=1.
//   fun3 010/011 on BRANCH: illegal=1, taken=0, npc=opc+PC_STEP.
//   misalign = taken & npc[1]; npc still driven unmodified; fetch/trap logic owns response.
//  Outputs registered: get_npc/link_we/taken/misalign/illegal high exactly the cycle after
//   RESOLVE, zero otherwise; npc/link_* hold last value.
//  Latency: opcode at cycle N, ops_valid at N+1 -> get_npc high at N+3. Each ops_valid stall
//   cycle adds 1.
//  Adds modulo 2^XLEN: wrap silently, no flag.
//  Control-flow opcode arriving in the get_npc cycle: accepted (state is IDLE), resolves normally.
//  Reset mid-operation: state -> IDLE, pending pulse dropped; no get_npc for the aborted instr.
// STRUCTURE
//  Shared defines header: OP_BRANCH/OP_JAL/OP_JALR/OP_NOP, BEQ..BGEU fun3 codes,
//   FSM state encodings.
//  Sub-module branch_cmp: combinational (fun3, a, b) -> {cond, illegal}; reused by later
//   forwarding work.
//  Top: FSM, capture regs, target adder, output regs.
// TESTING
//  BEQ opc=0x40 imm=0x10 rs1=rs2=5, ops_valid at N+1 -> get_npc@N+3, npc=0x50, taken=1.
//  BLT rs1=-1 rs2=1 -> taken, npc=opc+imm.
//  BLTU rs1=0xFFFFFFFF rs2=1 -> not taken, npc=opc+4.
//  JALR rd=1 rs1=0x1003 imm=0 opc=0x80 -> npc=0x1002, misalign=1, link_we=1,
//   link_rd=1, link_data=0x84.
//  ops_valid low 5 cycles -> busy stays 1, get_npc only 1 cycle after ops_valid+RESOLVE.
//  fun3=010 -> illegal=1, npc=opc+4; rst_n=0 in WAIT_OPS -> no get_npc, outputs 0.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared encodings for the branch resolver: opcodes, branch fun3 codes and FSM states.
// A helper identifies the opcodes that stall fetch and need resolution here.
package branch_resolver_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_NOP    = 7'b0010011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_OPS = 2'b01,
    ST_RESOLVE  = 2'b10
  } state_t;

  function automatic logic is_ctrl_flow(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/branch_resolver_cmp.sv
// Branch condition evaluator: maps (fun3, a, b) to a taken condition and flags the
// reserved fun3 encodings 010/011 as illegal. Purely combinational.
module branch_cmp
  import branch_resolver_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      fun3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            cond_o,
  output logic            illegal_o
);

  // Condition select by fun3
  always_comb begin
    cond_o    = 1'b0;
    illegal_o = 1'b0;
    case (fun3_i)
      F3_BEQ:  cond_o = (a_i == b_i);
      F3_BNE:  cond_o = (a_i != b_i);
      F3_BLT:  cond_o = ($signed(a_i) <  $signed(b_i));
      F3_BGE:  cond_o = ($signed(a_i) >= $signed(b_i));
      F3_BLTU: cond_o = (a_i <  b_i);
      F3_BGEU: cond_o = (a_i >= b_i);
      default: begin
        cond_o    = 1'b0;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves control-flow targets for a stalled fetch unit and produces the JAL/JALR link
// write-back. IDLE captures the instruction, WAIT_OPS latches operands, RESOLVE registers results.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      opcode,
  input  logic [2:0]      fun3,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] opc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            ops_valid,
  output logic [XLEN-1:0] npc,
  output logic            get_npc,
  output logic            link_we,
  output logic [4:0]      link_rd,
  output logic [XLEN-1:0] link_data,
  output logic            taken,
  output logic            misalign,
  output logic            illegal,
  output logic            busy
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  state_t          state_q, state_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      fun3_q, fun3_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] opc_q, opc_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;

  logic [XLEN-1:0] npc_q, npc_d;
  logic            get_npc_q, get_npc_d;
  logic            link_we_q, link_we_d;
  logic [4:0]      link_rd_q, link_rd_d;
  logic [XLEN-1:0] link_data_q, link_data_d;
  logic            taken_q, taken_d;
  logic            misalign_q, misalign_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] seq_pc_s, br_target_s, jalr_sum_s, jalr_target_s;
  logic            cmp_cond_s, cmp_illegal_s;

  // All adders wrap modulo 2^XLEN; JALR clears bit 0 of the sum.
  assign seq_pc_s      = opc_q + STEP;
  assign br_target_s   = opc_q + imm_q;
  assign jalr_sum_s    = rs1_q + imm_q;
  assign jalr_target_s = {jalr_sum_s[XLEN-1:1], 1'b0};

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .fun3_i    (fun3_q),
    .a_i       (rs1_q),
    .b_i       (rs2_q),
    .cond_o    (cmp_cond_s),
    .illegal_o (cmp_illegal_s)
  );

  // Next-state, capture and result computation
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    fun3_d      = fun3_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    opc_d       = opc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    npc_d       = npc_q;
    link_rd_d   = link_rd_q;
    link_data_d = link_data_q;
    get_npc_d   = 1'b0;
    link_we_d   = 1'b0;
    taken_d     = 1'b0;
    misalign_d  = 1'b0;
    illegal_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_ctrl_flow(opcode)) begin
          opcode_d = opcode;
          fun3_d   = fun3;
          rd_d     = rd;
          imm_d    = imm;
          opc_d    = opc;
          state_d  = ST_WAIT_OPS;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT_OPS: begin
        if (ops_valid) begin
          rs1_d   = rs1_val;
          rs2_d   = rs2_val;
          state_d = ST_RESOLVE;
        end else begin
          state_d = ST_WAIT_OPS;
        end
      end
      ST_RESOLVE: begin
        state_d   = ST_IDLE;
        get_npc_d = 1'b1;
        case (opcode_q)
          OP_JAL, OP_JALR: begin
            npc_d       = (opcode_q == OP_JALR) ? jalr_target_s : br_target_s;
            taken_d     = 1'b1;
            link_we_d   = 1'b1;
            link_rd_d   = rd_q;
            link_data_d = seq_pc_s;
          end
          default: begin
            illegal_d = cmp_illegal_s;
            taken_d   = cmp_cond_s & ~cmp_illegal_s;
            if (taken_d) begin
              npc_d = br_target_s;
            end else begin
              npc_d = seq_pc_s;
            end
          end
        endcase
        misalign_d = taken_d & npc_d[1];
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, capture and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      opcode_q    <= 7'd0;
      fun3_q      <= 3'd0;
      rd_q        <= 5'd0;
      imm_q       <= '0;
      opc_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      npc_q       <= '0;
      get_npc_q   <= 1'b0;
      link_we_q   <= 1'b0;
      link_rd_q   <= 5'd0;
      link_data_q <= '0;
      taken_q     <= 1'b0;
      misalign_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      fun3_q      <= fun3_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      opc_q       <= opc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      npc_q       <= npc_d;
      get_npc_q   <= get_npc_d;
      link_we_q   <= link_we_d;
      link_rd_q   <= link_rd_d;
      link_data_q <= link_data_d;
      taken_q     <= taken_d;
      misalign_q  <= misalign_d;
      illegal_q   <= illegal_d;
    end
  end

  assign npc       = npc_q;
  assign get_npc   = get_npc_q;
  assign link_we   = link_we_q;
  assign link_rd   = link_rd_q;
  assign link_data = link_data_q;
  assign taken     = taken_q;
  assign misalign  = misalign_q;
  assign illegal   = illegal_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_branch_resolver.sv
// Directed scoreboard bench for branch_resolver: expected results are pushed when operands
// are presented and compared when get_npc pulses.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic [31:0] npc;
    logic        taken;
    logic        misalign;
    logic        illegal;
    logic        link_we;
    logic [4:0]  link_rd;
    logic [31:0] link_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  fun3;
  logic [4:0]  rd;
  logic [31:0] imm, opc, rs1_val, rs2_val;
  logic        ops_valid;
  logic [31:0] npc, link_data;
  logic        get_npc, link_we, taken, misalign, illegal, busy;
  logic [4:0]  link_rd;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb_q[$];
  logic [4:0]  last_rd   = 5'd0;
  logic [31:0] last_data = 32'd0;

  branch_resolver #(.XLEN(XLEN), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .fun3(fun3), .rd(rd), .imm(imm),
    .opc(opc), .rs1_val(rs1_val), .rs2_val(rs2_val), .ops_valid(ops_valid),
    .npc(npc), .get_npc(get_npc), .link_we(link_we), .link_rd(link_rd),
    .link_data(link_data), .taken(taken), .misalign(misalign), .illegal(illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model of one control-flow instruction
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] d,
                                 input logic [31:0] im, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic t;
    e.taken = 1'b0; e.illegal = 1'b0; e.link_we = 1'b0;
    e.link_rd = last_rd; e.link_data = last_data;
    e.npc = pc + 32'd4;
    if (op == OP_JAL || op == OP_JALR) begin
      e.taken = 1'b1; e.link_we = 1'b1;
      e.link_rd = d; e.link_data = pc + 32'd4;
      e.npc = (op == OP_JAL) ? pc + im : ((a + im) & 32'hFFFF_FFFE);
    end else begin
      t = 1'b0;
      case (f3)
        3'b000: t = (a == b);
        3'b001: t = (a != b);
        3'b100: t = ($signed(a) < $signed(b));
        3'b101: t = !($signed(a) < $signed(b));
        3'b110: t = (a < b);
        3'b111: t = !(a < b);
        default: e.illegal = 1'b1;
      endcase
      e.taken = t;
      if (t) e.npc = pc + im;
    end
    e.misalign = e.taken & e.npc[1];
    return e;
  endfunction

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] d,
                           input logic [31:0] im, input logic [31:0] pc,
                           input logic [31:0] a, input logic [31:0] b, input int stall);
    exp_t e, got;
    int cnt;
    opcode = op; fun3 = f3; rd = d; imm = im; opc = pc;
    tick();
    check("prev_pulse_gone", {63'd0, get_npc}, 64'd0);
    check("taken_zero_idle", {63'd0, taken}, 64'd0);
    check("busy_wait", {63'd0, busy}, 64'd1);
    opcode = OP_NOP; fun3 = 3'd0; imm = 32'hDEAD_BEEF; opc = 32'hBAD0_0000;
    for (int i = 0; i < stall; i++) begin
      rs1_val = 32'hFFFF_0000; rs2_val = 32'h1234_5678;
      tick();
      check("stall_busy", {62'd0, busy, get_npc}, 64'd2);
    end
    rs1_val = a; rs2_val = b; ops_valid = 1'b1;
    e = model(op, f3, d, im, pc, a, b);
    sb_q.push_back(e);
    if (e.link_we) begin last_rd = e.link_rd; last_data = e.link_data; end
    cnt = 0;
    do begin
      tick();
      ops_valid = 1'b0; rs1_val = 32'h0; rs2_val = 32'h0;
      cnt++;
    end while (!get_npc && cnt < 8);
    check("latency", 64'(cnt), 64'd2);
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      check("npc", {32'd0, npc}, {32'd0, got.npc});
      check("taken", {63'd0, taken}, {63'd0, got.taken});
      check("misalign", {63'd0, misalign}, {63'd0, got.misalign});
      check("illegal", {63'd0, illegal}, {63'd0, got.illegal});
      check("link_we", {63'd0, link_we}, {63'd0, got.link_we});
      check("link_rd", {59'd0, link_rd}, {59'd0, got.link_rd});
      check("link_data", {32'd0, link_data}, {32'd0, got.link_data});
      check("busy_done", {63'd0, busy}, 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = OP_BRANCH; fun3 = 3'd0; rd = 5'd3; imm = 32'h10;
    opc = 32'h40; rs1_val = 32'd0; rs2_val = 32'd0; ops_valid = 1'b1;
    tick(); tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_pulses", {59'd0, get_npc, link_we, taken, misalign, illegal}, 64'd0);
    check("rst_npc", {32'd0, npc}, 64'd0);
    check("rst_link", {27'd0, link_rd, link_data}, 64'd0);
    rst_n = 1'b1; opcode = OP_NOP; ops_valid = 1'b0;
    tick();
    opcode = 7'b0110011;
    tick(); tick();
    check("non_cf_ignored", {62'd0, busy, get_npc}, 64'd0);

    run_instr(OP_BRANCH, F3_BEQ,  5'd0, 32'h10, 32'h40, 32'd5, 32'd5, 0);
    run_instr(OP_BRANCH, F3_BNE,  5'd0, 32'h10, 32'h40, 32'd5, 32'd5, 0);
    run_instr(OP_BRANCH, F3_BLT,  5'd0, 32'h20, 32'h100, 32'hFFFF_FFFF, 32'd1, 0);
    run_instr(OP_BRANCH, F3_BGE,  5'd0, 32'h20, 32'h100, 32'hFFFF_FFFF, 32'd1, 1);
    run_instr(OP_BRANCH, F3_BLTU, 5'd0, 32'h20, 32'h200, 32'hFFFF_FFFF, 32'd1, 0);
    run_instr(OP_BRANCH, F3_BGEU, 5'd0, 32'h20, 32'h200, 32'hFFFF_FFFF, 32'd1, 0);
    run_instr(OP_JALR,   3'd0,    5'd1, 32'h0,  32'h80,  32'h1003, 32'd0, 0);
    run_instr(OP_BRANCH, F3_BEQ,  5'd7, 32'h6,  32'h40,  32'd9, 32'd9, 0);
    run_instr(OP_JAL,    3'd0,    5'd5, 32'h20, 32'hFFFF_FFF0, 32'd0, 32'd0, 5);
    run_instr(OP_BRANCH, 3'b010,  5'd0, 32'h30, 32'h300, 32'd1, 32'd1, 0);
    run_instr(OP_BRANCH, 3'b011,  5'd0, 32'h30, 32'h300, 32'd1, 32'd2, 2);

    opcode = OP_BRANCH; fun3 = F3_BEQ; imm = 32'h10; opc = 32'h500;
    tick();
    opcode = OP_NOP; rst_n = 1'b0;
    tick();
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_outs", {27'd0, link_rd, link_data}, 64'd0);
    check("midrst_npc", {32'd0, npc}, 64'd0);
    last_rd = 5'd0; last_data = 32'd0;
    rst_n = 1'b1; ops_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      ops_valid = 1'b0;
      check("no_aborted_pulse", {62'd0, busy, get_npc}, 64'd0);
    end

    run_instr(OP_JAL, 3'd0, 5'd31, 32'h100, 32'h1000, 32'd0, 32'd0, 0);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
